// File: rtl/eerrl_pkg.sv
// Shared types and constants for the EER-RL reward datapath.
package eerrl_pkg;

    localparam int RW_WORD_W = 16;
    localparam int RW_TYPE_W = 3;

    localparam logic [RW_TYPE_W-1:0] PKT_DATA   = 3'd3;
    localparam logic [RW_TYPE_W-1:0] PKT_REWARD = 3'd4;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        DRAIN,
        SEND,
        DONE
    } rw_state_t;

    // All fields presented to the packet assembler while rValid is high.
    typedef struct packed {
        logic [RW_WORD_W-1:0] sourceID;
        logic [RW_WORD_W-1:0] energyLeft;
        logic [RW_WORD_W-1:0] qValue;
        logic [RW_WORD_W-1:0] sourceHops;
        logic [RW_WORD_W-1:0] destinationID;
        logic [RW_WORD_W-1:0] chosenCH;
        logic [RW_WORD_W-1:0] hopsFromCH;
        logic [RW_TYPE_W-1:0] packetType;
    } reward_pkt_t;

endpackage

// File: rtl/nt_max_scan.sv
// Walks the neighbour table once per start pulse and keeps the largest
// Q-value seen among valid entries (table read data arrives one cycle
// after the index).
module nt_max_scan #(
    parameter int WORD_WIDTH = 16,
    parameter int NT_DEPTH   = 32,
    localparam int IDX_W     = $clog2(NT_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  mNodeValid,
    input  logic [WORD_WIDTH-1:0] mNodeQValue,
    output logic [IDX_W-1:0]      index,
    output logic [WORD_WIDTH-1:0] best,
    output logic                  anyValid,
    output logic                  scan_done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NT_DEPTH - 1);

    logic             running;
    logic             rdVld;
    logic [IDX_W-1:0] idx;

    // Index counter, read-latency delay of the running flag, and max accumulator.
    always_ff @(posedge clk) begin
        if (rst) begin
            running  <= 1'b0;
            rdVld    <= 1'b0;
            idx      <= '0;
            best     <= '0;
            anyValid <= 1'b0;
        end else begin
            rdVld <= running;
            if (start) begin
                running  <= 1'b1;
                idx      <= '0;
                best     <= '0;
                anyValid <= 1'b0;
            end else begin
                if (running) begin
                    if (idx == LAST_IDX) begin
                        running <= 1'b0;
                        idx     <= '0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                if (rdVld && mNodeValid) begin
                    anyValid <= 1'b1;
                    if (mNodeQValue > best) begin
                        best <= mNodeQValue;
                    end
                end
            end
        end
    end

    assign index     = idx;
    assign scan_done = rdVld & ~running;

endmodule

// File: rtl/reward_engine.sv
// Per-node reward packet builder: detects unicast/broadcast triggers,
// scans the neighbour table for the best Q-value, and hands the packet to
// the assembler over a valid/ready handshake.
module reward_engine
    import eerrl_pkg::*;
#(
    parameter int                    WORD_WIDTH = 16,
    parameter int                    NT_DEPTH   = 32,
    parameter int                    PKT_TYPE_W = 3,
    parameter logic [WORD_WIDTH-1:0] BCAST_ID   = '1,
    localparam int                   IDX_W      = $clog2(NT_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [PKT_TYPE_W-1:0] fPacketType,
    input  logic [WORD_WIDTH-1:0] fSourceID,
    input  logic                  iAmDestination,
    input  logic                  low_E,
    input  logic [WORD_WIDTH-1:0] myNodeID,
    input  logic [WORD_WIDTH-1:0] myEnergy,
    input  logic [WORD_WIDTH-1:0] hopsFromSink,
    input  logic [WORD_WIDTH-1:0] myQValue,
    input  logic                  role,
    input  logic [WORD_WIDTH-1:0] chosenCH,
    input  logic [WORD_WIDTH-1:0] hopsFromCH,
    input  logic                  mNodeValid,
    input  logic [WORD_WIDTH-1:0] mNodeQValue,
    output logic [IDX_W-1:0]      nTableIndex_reward,
    output logic                  rValid,
    input  logic                  rReady,
    output logic [WORD_WIDTH-1:0] rSourceID,
    output logic [WORD_WIDTH-1:0] rEnergyLeft,
    output logic [WORD_WIDTH-1:0] rQValue,
    output logic [WORD_WIDTH-1:0] rSourceHops,
    output logic [WORD_WIDTH-1:0] rDestinationID,
    output logic [WORD_WIDTH-1:0] rChosenCH,
    output logic [WORD_WIDTH-1:0] rHopsFromCH,
    output logic [PKT_TYPE_W-1:0] rPacketType,
    output logic                  reward_done,
    output logic                  busy,
    output logic [7:0]            dropCount
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NT_DEPTH - 1);

    rw_state_t state, stateNext;

    logic                  lowEQ;
    logic                  trigU;
    logic                  trigB;
    logic                  startScan;
    logic                  useUnicast;
    logic                  pending;
    logic                  pendingNext;
    logic                  consuming;
    logic                  bDrop;
    logic [1:0]            dropInc;
    logic [WORD_WIDTH-1:0] destQ;
    logic [WORD_WIDTH-1:0] energyQ;
    logic [WORD_WIDTH-1:0] qLatchQ;
    reward_pkt_t           pktQ;
    reward_pkt_t           pktOut;

    logic [IDX_W-1:0]      scanIndex;
    logic [WORD_WIDTH-1:0] scanBest;
    logic                  scanAny;
    logic                  scanDone;

    function automatic logic [7:0] satAdd8(input logic [7:0] a, input logic [1:0] inc);
        logic [8:0] s;
        s = {1'b0, a} + {7'b0, inc};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    assign trigU = en & iAmDestination & (fPacketType == PKT_DATA);
    assign trigB = low_E & ~lowEQ;

    nt_max_scan #(
        .WORD_WIDTH (WORD_WIDTH),
        .NT_DEPTH   (NT_DEPTH)
    ) uScan (
        .clk         (clk),
        .rst         (rst),
        .start       (startScan),
        .mNodeValid  (mNodeValid),
        .mNodeQValue (mNodeQValue),
        .index       (scanIndex),
        .best        (scanBest),
        .anyValid    (scanAny),
        .scan_done   (scanDone)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next state, trigger arbitration, pending/drop decisions and handshake outputs.
    always_comb begin
        stateNext   = state;
        startScan   = 1'b0;
        useUnicast  = 1'b0;
        pendingNext = pending;
        consuming   = 1'b0;
        bDrop       = 1'b0;
        dropInc     = 2'd0;
        rValid      = 1'b0;
        reward_done = 1'b0;
        busy        = (state != IDLE);
        case (state)
            IDLE: begin
                if (trigU) begin
                    stateNext  = SCAN;
                    startScan  = 1'b1;
                    useUnicast = 1'b1;
                    if (trigB) begin
                        pendingNext = 1'b1;
                    end
                end else if (trigB) begin
                    stateNext = SCAN;
                    startScan = 1'b1;
                end
            end
            SCAN: begin
                if (scanIndex == LAST_IDX) begin
                    stateNext = DRAIN;
                end
            end
            DRAIN: begin
                if (scanDone) begin
                    stateNext = SEND;
                end
            end
            SEND: begin
                rValid = 1'b1;
                if (rReady) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                reward_done = 1'b1;
                if (pending) begin
                    stateNext   = SCAN;
                    startScan   = 1'b1;
                    consuming   = 1'b1;
                    pendingNext = 1'b0;
                end else begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
        // While busy a broadcast edge may occupy the single pending slot
        // (including the slot being freed this cycle); everything else is lost.
        if (state != IDLE) begin
            if (trigB && (!pending || consuming)) begin
                pendingNext = 1'b1;
            end else begin
                bDrop = trigB;
            end
            dropInc = {1'b0, trigU} + {1'b0, bDrop};
        end
    end

    // Control registers: low_E edge history, pending broadcast flag, drop counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            lowEQ     <= 1'b0;
            pending   <= 1'b0;
            dropCount <= 8'd0;
        end else begin
            lowEQ     <= low_E;
            pending   <= pendingNext;
            dropCount <= satAdd8(dropCount, dropInc);
        end
    end

    // Trigger-time latch of destination, energy and fallback Q-value.
    always_ff @(posedge clk) begin
        if (rst) begin
            destQ   <= '0;
            energyQ <= '0;
            qLatchQ <= '0;
        end else if (startScan) begin
            destQ   <= useUnicast ? fSourceID : BCAST_ID;
            energyQ <= myEnergy;
            qLatchQ <= myQValue;
        end
    end

    // Packet register, loaded on the way into SEND and frozen until the next packet.
    always_ff @(posedge clk) begin
        if (rst) begin
            pktQ <= '0;
        end else if (state == DRAIN) begin
            pktQ.sourceID      <= myNodeID;
            pktQ.energyLeft    <= energyQ;
            pktQ.qValue        <= '0;
            pktQ.sourceHops    <= hopsFromSink;
            pktQ.destinationID <= destQ;
            pktQ.chosenCH      <= chosenCH;
            pktQ.hopsFromCH    <= role ? '0 : hopsFromCH;
            pktQ.packetType    <= PKT_REWARD;
        end
    end

    // The scan result settles on the same edge that enters SEND, so the
    // Q-value field is taken straight from the accumulator (held while idle).
    always_comb begin
        pktOut        = pktQ;
        pktOut.qValue = scanAny ? scanBest : qLatchQ;
    end

    assign nTableIndex_reward = scanIndex;
    assign rSourceID          = pktOut.sourceID;
    assign rEnergyLeft        = pktOut.energyLeft;
    assign rQValue            = pktOut.qValue;
    assign rSourceHops        = pktOut.sourceHops;
    assign rDestinationID     = pktOut.destinationID;
    assign rChosenCH          = pktOut.chosenCH;
    assign rHopsFromCH        = pktOut.hopsFromCH;
    assign rPacketType        = pktOut.packetType;

endmodule

// File: tb/tb_reward_engine.sv
// Directed bench for reward_engine with a registered neighbour-table model.
module tb_reward_engine;

    logic        clk;
    logic        rst;
    logic        en;
    logic [2:0]  fPacketType;
    logic [15:0] fSourceID;
    logic        iAmDestination;
    logic        low_E;
    logic [15:0] myNodeID;
    logic [15:0] myEnergy;
    logic [15:0] hopsFromSink;
    logic [15:0] myQValue;
    logic        role;
    logic [15:0] chosenCH;
    logic [15:0] hopsFromCH;
    logic        mNodeValid;
    logic [15:0] mNodeQValue;
    logic [4:0]  nTableIndex_reward;
    logic        rValid;
    logic        rReady;
    logic [15:0] rSourceID;
    logic [15:0] rEnergyLeft;
    logic [15:0] rQValue;
    logic [15:0] rSourceHops;
    logic [15:0] rDestinationID;
    logic [15:0] rChosenCH;
    logic [15:0] rHopsFromCH;
    logic [2:0]  rPacketType;
    logic        reward_done;
    logic        busy;
    logic [7:0]  dropCount;

    logic        ntValid [32];
    logic [15:0] ntQ     [32];

    int testCnt = 0;
    int failCnt = 0;
    int cyc;
    int seen;

    reward_engine dut (
        .clk                (clk),
        .rst                (rst),
        .en                 (en),
        .fPacketType        (fPacketType),
        .fSourceID          (fSourceID),
        .iAmDestination     (iAmDestination),
        .low_E              (low_E),
        .myNodeID           (myNodeID),
        .myEnergy           (myEnergy),
        .hopsFromSink       (hopsFromSink),
        .myQValue           (myQValue),
        .role               (role),
        .chosenCH           (chosenCH),
        .hopsFromCH         (hopsFromCH),
        .mNodeValid         (mNodeValid),
        .mNodeQValue        (mNodeQValue),
        .nTableIndex_reward (nTableIndex_reward),
        .rValid             (rValid),
        .rReady             (rReady),
        .rSourceID          (rSourceID),
        .rEnergyLeft        (rEnergyLeft),
        .rQValue            (rQValue),
        .rSourceHops        (rSourceHops),
        .rDestinationID     (rDestinationID),
        .rChosenCH          (rChosenCH),
        .rHopsFromCH        (rHopsFromCH),
        .rPacketType        (rPacketType),
        .reward_done        (reward_done),
        .busy               (busy),
        .dropCount          (dropCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Neighbour table: one-cycle read latency.
    always @(posedge clk) begin
        mNodeValid  <= ntValid[nTableIndex_reward];
        mNodeQValue <= ntQ[nTableIndex_reward];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCnt++;
        assert (obs === exp) else begin
            failCnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clearTable();
        for (int i = 0; i < 32; i++) begin
            ntValid[i] = 1'b0;
            ntQ[i]     = 16'h0000;
        end
    endtask

    task automatic waitValid(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            en = 1'b0;
        end while (!rValid && n < 200);
        check("valid_timeout", 32'(rValid), 1);
    endtask

    task automatic waitDone(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!reward_done && n < 200);
        check("done_timeout", 32'(reward_done), 1);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; fPacketType = 3'd3; fSourceID = 16'd5;
        iAmDestination = 1'b1; low_E = 1'b0; myNodeID = 16'h0011;
        myEnergy = 16'h0AAA; hopsFromSink = 16'd3; myQValue = 16'h0050;
        role = 1'b0; chosenCH = 16'h0022; hopsFromCH = 16'd2; rReady = 1'b1;
        clearTable();
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_rValid", 32'(rValid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_index", 32'(nTableIndex_reward), 0);
        check("rst_done", 32'(reward_done), 0);
        check("rst_drop", 32'(dropCount), 0);
        check("rst_q", 32'(rQValue), 0);
        rst = 1'b0;
        @(negedge clk);

        // 1: unicast, two valid entries plus an invalid larger one
        ntValid[2] = 1'b1; ntQ[2] = 16'h0300;
        ntValid[7] = 1'b1; ntQ[7] = 16'h0900;
        ntValid[9] = 1'b0; ntQ[9] = 16'hFFFF;
        en = 1'b1; cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            en = 1'b0;
            if (cyc == 1)  check("t1_idx0", 32'(nTableIndex_reward), 0);
            if (cyc == 3)  check("t1_idx2", 32'(nTableIndex_reward), 2);
            if (cyc == 32) check("t1_idx31", 32'(nTableIndex_reward), 31);
        end while (!rValid && cyc < 200);
        check("t1_latency", 32'(cyc), 34);
        check("t1_q", 32'(rQValue), 'h0900);
        check("t1_dest", 32'(rDestinationID), 5);
        check("t1_src", 32'(rSourceID), 'h0011);
        check("t1_energy", 32'(rEnergyLeft), 'h0AAA);
        check("t1_hops", 32'(rSourceHops), 3);
        check("t1_ch", 32'(rChosenCH), 'h0022);
        check("t1_hopsch", 32'(rHopsFromCH), 2);
        check("t1_type", 32'(rPacketType), 4);
        check("t1_idx_hold", 32'(nTableIndex_reward), 0);
        @(negedge clk);
        check("t1_done", 32'(reward_done), 1);
        check("t1_valid_off", 32'(rValid), 0);
        @(negedge clk);
        check("t1_done_pulse", 32'(reward_done), 0);
        check("t1_idle", 32'(busy), 0);

        // Non-data packet type must not trigger
        fPacketType = 3'd4; en = 1'b1;
        @(negedge clk); en = 1'b0;
        @(negedge clk);
        check("nodata_busy", 32'(busy), 0);
        fPacketType = 3'd3;

        // 2: empty table, cluster-head role
        clearTable();
        myQValue = 16'h0123; role = 1'b1; hopsFromCH = 16'd7;
        en = 1'b1;
        waitValid(cyc);
        check("t2_latency", 32'(cyc), 34);
        check("t2_q", 32'(rQValue), 'h0123);
        check("t2_hopsch", 32'(rHopsFromCH), 0);
        waitDone(cyc);
        role = 1'b0;
        @(negedge clk);

        // 3: unicast and low_E rise together
        ntValid[4] = 1'b1; ntQ[4] = 16'h0444;
        fSourceID = 16'h0009; en = 1'b1; low_E = 1'b1;
        waitValid(cyc);
        check("t3_lat1", 32'(cyc), 34);
        check("t3_dest1", 32'(rDestinationID), 'h0009);
        check("t3_q1", 32'(rQValue), 'h0444);
        waitDone(cyc);
        check("t3_done1_lat", 32'(cyc), 1);
        waitValid(cyc);
        check("t3_lat2", 32'(cyc), 34);
        check("t3_dest2", 32'(rDestinationID), 'hFFFF);
        waitDone(cyc);
        @(negedge clk);
        check("t3_idle", 32'(busy), 0);
        check("t3_drop", 32'(dropCount), 0);
        low_E = 1'b0;
        @(negedge clk);
        check("t3_fall_notrig", 32'(busy), 0);

        // 4: backpressure in SEND; last-entry Q exercised
        clearTable();
        ntValid[0] = 1'b1; ntQ[0] = 16'h0100;
        ntValid[31] = 1'b1; ntQ[31] = 16'h0777;
        myNodeID = 16'h0011; fSourceID = 16'h0005;
        rReady = 1'b0; en = 1'b1;
        waitValid(cyc);
        check("t4_latency", 32'(cyc), 34);
        myNodeID = 16'h0099;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t4_hold_valid", 32'(rValid), 1);
            check("t4_hold_q", 32'(rQValue), 'h0777);
            check("t4_hold_src", 32'(rSourceID), 'h0011);
            check("t4_hold_nodone", 32'(reward_done), 0);
        end
        rReady = 1'b1;
        @(negedge clk);
        check("t4_done", 32'(reward_done), 1);
        check("t4_valid_off", 32'(rValid), 0);
        @(negedge clk);
        check("t4_single_done", 32'(reward_done), 0);
        myNodeID = 16'h0011;

        // 5: drops during a scan, then saturation
        en = 1'b1; cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            en = (cyc == 5 || cyc == 10 || cyc == 15);
        end while (!reward_done && cyc < 200);
        check("t5_done_seen", 32'(reward_done), 1);
        check("t5_drop3", 32'(dropCount), 3);
        @(negedge clk);
        rReady = 1'b0; en = 1'b1;
        waitValid(cyc);
        en = 1'b1;
        repeat (100) @(negedge clk);
        check("t5_drop103", 32'(dropCount), 103);
        repeat (200) @(negedge clk);
        en = 1'b0;
        check("t5_drop_sat", 32'(dropCount), 255);
        rReady = 1'b1;
        waitDone(cyc);
        @(negedge clk);
        check("t5_sat_hold", 32'(dropCount), 255);

        // 6: reset during SEND with a broadcast pending
        rReady = 1'b0; en = 1'b1;
        waitValid(cyc);
        low_E = 1'b1;
        @(negedge clk);
        rst = 1'b1; low_E = 1'b0;
        @(negedge clk);
        check("t6_valid", 32'(rValid), 0);
        check("t6_busy", 32'(busy), 0);
        check("t6_index", 32'(nTableIndex_reward), 0);
        check("t6_done", 32'(reward_done), 0);
        check("t6_drop", 32'(dropCount), 0);
        rst = 1'b0; rReady = 1'b1; seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy || reward_done || rValid) seen++;
        end
        check("t6_no_pending", 32'(seen), 0);

        $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
        $finish;
    end

endmodule
